// File: rtl/core_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Package  : core_pkg                                                         |
// | Desc     : Shared widths and shifter select encoding for decoder, register  |
// |            file and shifter of the single-cycle core.                       |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
package core_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int SHAMT_W    = 5;

    // Encoding is chosen so that bit 0 selects arithmetic fill for right shifts.
    typedef enum logic [1:0] {
        SHIFT_SRL = 2'b00,
        SHIFT_SRA = 2'b01,
        SHIFT_SLL = 2'b11
    } shift_sel_e;

endpackage : core_pkg
`default_nettype wire

// File: rtl/regfile.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : regfile                                                          |
// | Desc     : 32 x XLEN RISC-V integer register file, two combinational read   |
// |            ports, one synchronous write port, x0 hardwired to zero.         |
// |            Define REGFILE_BYPASS_EN for same-cycle write-through reads.     |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module regfile
    import core_pkg::*;
#(
    parameter int XLEN     = core_pkg::XLEN,
    parameter int NUM_REGS = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [REG_ADDR_W-1:0] i_rs1_addr,
    input  logic [REG_ADDR_W-1:0] i_rs2_addr,
    input  logic [REG_ADDR_W-1:0] i_rd_addr,
    input  logic [XLEN-1:0]       i_rd_data,
    input  logic                  i_rd_wren,
    output logic [XLEN-1:0]       o_rs1_data,
    output logic [XLEN-1:0]       o_rs2_data,
    output logic [SHAMT_W-1:0]    o_shamt
);

    // Entry 0 is a constant; only x1..x(NUM_REGS-1) own flops.
    logic [XLEN-1:0] w_regs [0:NUM_REGS-1];
    logic            w_wr_ok;
    logic [XLEN-1:0] w_rs1_data;
    logic [XLEN-1:0] w_rs2_data;

    assign w_regs[0] = '0;
    assign w_wr_ok   = i_rd_wren && (i_rd_addr != '0);

    for (genvar gi = 1; gi < NUM_REGS; gi++) begin : g_reg
        logic [XLEN-1:0] r_q;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_q <= '0;
            end else if (w_wr_ok && (i_rd_addr == REG_ADDR_W'(gi))) begin
                r_q <= i_rd_data;
            end
        end

        assign w_regs[gi] = r_q;
    end

    always_comb begin
        w_rs1_data = w_regs[i_rs1_addr];
        w_rs2_data = w_regs[i_rs2_addr];
`ifdef REGFILE_BYPASS_EN
        // Gated by reset so outputs stay zero while reset is held.
        if (i_rst_n && w_wr_ok && (i_rs1_addr == i_rd_addr)) begin
            w_rs1_data = i_rd_data;
        end
        if (i_rst_n && w_wr_ok && (i_rs2_addr == i_rd_addr)) begin
            w_rs2_data = i_rd_data;
        end
`endif
    end

    assign o_rs1_data = w_rs1_data;
    assign o_rs2_data = w_rs2_data;
    assign o_shamt    = w_rs2_data[SHAMT_W-1:0];

endmodule : regfile
`default_nettype wire
